prod_accum: RTL and testbench
=============================

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter: ACC_W, default 20, accumulator and result width in bits; legal range 17..32.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: clear  input  1  synchronous abort; drops the partial frame and any pending result.
REQ-005 Port: len  input  8  frame length in products, sampled only on the first accept of a frame; 0 means 256.
REQ-006 Port: in_valid  input  1  in_data carries a product this cycle.
REQ-007 Port: in_data  input  16  signed two's-complement product from the upstream 8x8 signed multiplier.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: out_valid  output  1  out_data holds a completed frame sum.
REQ-010 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 Port: out_data  output  ACC_W  signed frame sum.
REQ-012 Port: out_ovf  output  1  frame overflowed ACC_W; qualified by out_valid.

Function
REQ-013 An accept occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-014 The FSM has states IDLE, ACC and HOLD; in_ready is 1 in IDLE and ACC, and equals out_ready in HOLD.
REQ-015 IDLE accept: acc = sign-extended in_data, cnt = 1, len_q = len (0 -> 256), ovf = 0; next state HOLD if len_q == 1, else ACC.
REQ-016 ACC accept: acc = acc + sext(in_data), cnt = cnt + 1; next state HOLD when the new cnt equals len_q.
REQ-017 ACC with in_valid = 0 holds all state; there is no timeout.
REQ-018 HOLD: out_valid = 1; out_data and out_ovf stay stable until out_ready = 1.
REQ-019 HOLD with out_ready = 1 and in_valid = 0: out_valid deasserts next cycle and the FSM returns to IDLE.
REQ-020 HOLD with out_ready = 1 and in_valid = 1: the result is consumed and the accept starts a new frame per REQ-015 in the same cycle, giving zero-bubble throughput.
REQ-021 Result latency: out_valid rises on the cycle after the final accept.
REQ-022 clear = 1 has priority over every other input: the next state is IDLE and out_valid = 0; an accept coincident with clear is discarded.
REQ-023 Sign extension is from bit 15 to ACC_W; cnt is 9 bits wide.
REQ-024 Overflow is detected per add: both operands have the same sign and the sum sign differs.

Reset
REQ-025 rst = 1 forces: state IDLE, acc = 0, cnt = 0, len_q = 0, out_valid = 0, out_data = 0, out_ovf = 0.
REQ-026 rst has priority over clear.
REQ-027 rst asserted mid-frame or in HOLD discards all work; in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-028 The macro PROD_ACCUM_SAT_EN, when defined, saturates: on overflow acc clamps to +(2^(ACC_W-1))-1 or -2^(ACC_W-1) by operand sign, and later adds continue from the clamped value.
REQ-029 With PROD_ACCUM_SAT_EN defined, ovf is sticky per frame and drives out_ovf.
REQ-030 Without PROD_ACCUM_SAT_EN, the sum wraps modulo 2^ACC_W and out_ovf is constant 0.

Verification
REQ-031 Test 1: len=4, products 100, -50, 7, -1 accepted back-to-back, out_ready=1 -> out_data=56, out_ovf=0, out_valid for 1 cycle, 1 cycle after the 4th accept.
REQ-032 Test 2: len=1 and in_data=16'h8000 accepted continuously with out_ready=1 -> out_data=-32768 every cycle, in_ready stays 1, no bubbles.
REQ-033 Test 3: len=0, 256 accepts of 16384, ACC_W=20 -> with PROD_ACCUM_SAT_EN: out_data=524287, out_ovf=1; without it: out_data=0 (wrap of 2^22), out_ovf=0.
REQ-034 Test 4: frame done, out_ready=0 for 5 cycles -> out_data stable, in_ready=0; then out_ready=1 -> out_valid falls next cycle.
REQ-035 Test 5: clear pulsed after 2 of 4 accepts, then a new len=2 frame of 3 and 4 -> out_data=7, with no residue from the aborted frame.
REQ-036 Test 6: rst pulsed while in HOLD -> out_valid=0 and out_data=0 next cycle; in_ready=1.

Source files
------------

// File: rtl/prod_accum.sv
// Frame accumulator for signed 16-bit products with a ready/valid result hold.
// Define PROD_ACCUM_SAT_EN to saturate on overflow and report a sticky out_ovf.
module prod_accum #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [7:0]       len,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [8:0]       len_q, len_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] add_res;
  logic [8:0]       len_eff;
  logic [8:0]       cnt_inc;
  logic             accept;
`ifdef PROD_ACCUM_SAT_EN
  logic             add_ovf;
`endif

  assign in_ready  = (state_q != HOLD) || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
`ifdef PROD_ACCUM_SAT_EN
  assign out_ovf   = ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

  always_comb begin
    ext     = {{(ACC_W-16){in_data[15]}}, in_data};
    sum     = acc_q + ext;
    len_eff = (len == 8'd0) ? 9'd256 : {1'b0, len};
    cnt_inc = cnt_q + 9'd1;
    accept  = in_valid && in_ready;
`ifdef PROD_ACCUM_SAT_EN
    add_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    // Clamp direction follows the shared operand sign.
    if (add_ovf)
      add_res = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      add_res = sum;
`else
    add_res = sum;
`endif

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          // A new frame may start straight out of HOLD when the result is taken.
          if (accept) begin
            acc_d   = ext;
            cnt_d   = 9'd1;
            len_d   = len_eff;
            ovf_d   = 1'b0;
            state_d = (len_eff == 9'd1) ? HOLD : ACC;
          end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = add_res;
            cnt_d = cnt_inc;
`ifdef PROD_ACCUM_SAT_EN
            ovf_d = ovf_q || add_ovf;
`endif
            if (cnt_inc == len_q) state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: vector table plus hand sequences for
// the 256-product frame and reset while holding a result.
module tb_prod_accum;

  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [7:0]       len;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic        clr;
    logic [7:0]  ln;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    int          e_d;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic clr, logic [7:0] ln, logic iv, int d, logic ordy,
                              logic e_ir, logic e_ov, logic chk_d, int e_d);
    vec_t v;
    v.clr = clr; v.ln = ln; v.iv = iv; v.d = d[15:0]; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  initial begin
    int exp_sum;
    int exp_ovf;
    rst = 1'b1; clear = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;

    // clr len iv data ordy | in_ready out_valid chk_data out_data
    // len=4 frame 100,-50,7,-1 -> 56
    vq.push_back(mk(0, 4, 1, 100,    1, 1, 0, 1, 0));
    vq.push_back(mk(0, 4, 1, -50,    1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4, 1, 7,      1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4, 1, -1,     1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4, 0, 0,      1, 1, 1, 1, 56));
    vq.push_back(mk(0, 4, 0, 0,      1, 1, 0, 0, 0));
    // len=1 back-to-back 0x8000
    vq.push_back(mk(0, 1, 1, 32'h8000, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 32'h8000, 1, 1, 1, 1, -32768));
    vq.push_back(mk(0, 1, 1, 32'h8000, 1, 1, 1, 1, -32768));
    vq.push_back(mk(0, 1, 1, 32'h8000, 1, 1, 1, 1, -32768));
    vq.push_back(mk(0, 1, 0, 0,      1, 1, 1, 1, -32768));
    vq.push_back(mk(0, 1, 0, 0,      1, 1, 0, 0, 0));
    // len=2 frame 5,6 held for 5 cycles with out_ready=0
    vq.push_back(mk(0, 2, 1, 5,      0, 1, 0, 0, 0));
    vq.push_back(mk(0, 2, 1, 6,      0, 1, 0, 0, 0));
    vq.push_back(mk(0, 2, 1, 99,     0, 0, 1, 1, 11));
    vq.push_back(mk(0, 2, 1, 99,     0, 0, 1, 1, 11));
    vq.push_back(mk(0, 2, 1, 99,     0, 0, 1, 1, 11));
    vq.push_back(mk(0, 2, 1, 99,     0, 0, 1, 1, 11));
    vq.push_back(mk(0, 2, 1, 99,     0, 0, 1, 1, 11));
    vq.push_back(mk(0, 2, 0, 0,      1, 1, 1, 1, 11));
    vq.push_back(mk(0, 2, 0, 0,      1, 1, 0, 0, 0));
    // clear after 2 of 4, then len=2 frame 3,4 -> 7
    vq.push_back(mk(0, 4, 1, 1000,   1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4, 1, 2000,   1, 1, 0, 0, 0));
    vq.push_back(mk(1, 4, 1, 500,    1, 1, 0, 0, 0));
    vq.push_back(mk(0, 2, 1, 3,      1, 1, 0, 0, 0));
    vq.push_back(mk(0, 2, 1, 4,      1, 1, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0,      1, 1, 1, 1, 7));
    vq.push_back(mk(0, 2, 0, 0,      1, 1, 0, 0, 0));

    repeat (2) @(posedge clk);

    // Row 0 observes the state left by reset; out_data is checked to be 0 there.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      clear = vq[i].clr; len = vq[i].ln; in_valid = vq[i].iv;
      in_data = vq[i].d; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vq[i].e_ir));
      chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vq[i].e_ov));
      if (vq[i].chk_d) begin
        chk($sformatf("vec%0d out_data", i), sdata(), vq[i].e_d);
        chk($sformatf("vec%0d out_ovf", i), int'(out_ovf), 0);
      end
    end

    // len=0 means 256 products; 256 * 16384 = 2^22
`ifdef PROD_ACCUM_SAT_EN
    exp_sum = 524287; exp_ovf = 1;
`else
    exp_sum = 0;      exp_ovf = 0;
`endif
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      clear = 1'b0; len = 8'd0; in_valid = 1'b1; in_data = 16'd16384; out_ready = 1'b1;
      #1;
      chk($sformatf("len256 acc%0d in_ready", i), int'(in_ready), 1);
      chk($sformatf("len256 acc%0d out_valid", i), int'(out_valid), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("len256 out_valid", int'(out_valid), 1);
    chk("len256 out_data", sdata(), exp_sum);
    chk("len256 out_ovf", int'(out_ovf), exp_ovf);
    @(negedge clk);
    #1;
    chk("len256 out_valid drop", int'(out_valid), 0);

    // reset while holding a result, with clear also asserted
    @(negedge clk);
    len = 8'd1; in_valid = 1'b1; in_data = 16'd77; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("hold out_valid", int'(out_valid), 1);
    chk("hold out_data", sdata(), 77);
    chk("hold in_ready", int'(in_ready), 0);
    rst = 1'b1; clear = 1'b1;
    @(negedge clk);
    rst = 1'b0; clear = 1'b0;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", sdata(), 0);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_ovf", int'(out_ovf), 0);

    // a fresh len=2 frame right after reset: -3 + -4
    @(negedge clk);
    len = 8'd2; in_valid = 1'b1; in_data = 16'hFFFD; out_ready = 1'b1;
    @(negedge clk);
    in_data = 16'hFFFC;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post-rst out_valid", int'(out_valid), 1);
    chk("post-rst out_data", sdata(), -7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
